// File: rtl/stb_dcache_arbiter_if.sv
// Bundles the load-port, store-buffer and dcache buses around the arbiter.
// The arbiter connects through the slave modport and the environment through the master modport.
interface stb_dcache_arbiter_if #(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int BYTE_SEL_WIDTH = 4
);

   logic [ADDR_WIDTH-1:0]     lsummu2arb_addr;
   logic [BYTE_SEL_WIDTH-1:0] lsummu2arb_sel_byte;
   logic                      lsummu2arb_req;
   logic [DATA_WIDTH-1:0]     arb2lsummu_rdata;
   logic                      arb2lsummu_ack;

   logic [ADDR_WIDTH-1:0]     stb2arb_addr;
   logic [DATA_WIDTH-1:0]     stb2arb_wdata;
   logic [BYTE_SEL_WIDTH-1:0] stb2arb_sel_byte;
   logic                      stb2arb_req;
   logic                      stb2arb_full;
   logic                      arb2stb_ack;

   logic [ADDR_WIDTH-1:0]     arb2dcache_addr;
   logic [DATA_WIDTH-1:0]     arb2dcache_wdata;
   logic [BYTE_SEL_WIDTH-1:0] arb2dcache_sel_byte;
   logic                      arb2dcache_w_en;
   logic                      arb2dcache_req;
   logic [DATA_WIDTH-1:0]     dcache2arb_rdata;
   logic                      dcache2arb_ack;

   modport slave (
      input  lsummu2arb_addr, lsummu2arb_sel_byte, lsummu2arb_req,
      output arb2lsummu_rdata, arb2lsummu_ack,
      input  stb2arb_addr, stb2arb_wdata, stb2arb_sel_byte, stb2arb_req, stb2arb_full,
      output arb2stb_ack,
      output arb2dcache_addr, arb2dcache_wdata, arb2dcache_sel_byte, arb2dcache_w_en, arb2dcache_req,
      input  dcache2arb_rdata, dcache2arb_ack
   );

   modport master (
      output lsummu2arb_addr, lsummu2arb_sel_byte, lsummu2arb_req,
      input  arb2lsummu_rdata, arb2lsummu_ack,
      output stb2arb_addr, stb2arb_wdata, stb2arb_sel_byte, stb2arb_req, stb2arb_full,
      input  arb2stb_ack,
      input  arb2dcache_addr, arb2dcache_wdata, arb2dcache_sel_byte, arb2dcache_w_en, arb2dcache_req,
      output dcache2arb_rdata, dcache2arb_ack
   );

endinterface

// File: rtl/stb_dcache_arbiter.sv
// Arbitrates the single dcache port between LSU loads and store-buffer drains,
// favouring loads but forcing a drain when the buffer is full or loads have starved it.
module stb_dcache_arbiter #(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int BYTE_SEL_WIDTH = 4,
   parameter int STARVE_LIMIT   = 4
) (
   input logic                 clk,
   input logic                 rst_n,
   stb_dcache_arbiter_if.slave bus
);

   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      STORE = 2'd2
   } state_t;

   state_t     state;
   state_t     next_state;
   logic [3:0] starve_cnt;
   logic       grant_load;
   logic       grant_store;
   logic       load_done;
   logic       store_done;

   // A dcache ack only means something while a transaction is outstanding.
   assign load_done  = (state == LOAD)  && bus.dcache2arb_ack;
   assign store_done = (state == STORE) && bus.dcache2arb_ack;

   assign bus.arb2lsummu_ack   = load_done;
   assign bus.arb2stb_ack      = store_done;
   assign bus.arb2lsummu_rdata = load_done ? bus.dcache2arb_rdata : '0;

   always_comb begin
      next_state  = state;
      grant_load  = 1'b0;
      grant_store = 1'b0;
      case (state)
         IDLE: begin
            if (bus.stb2arb_req && (bus.stb2arb_full || (starve_cnt == LIMIT))) begin
               grant_store = 1'b1;
               next_state  = STORE;
            end else if (bus.lsummu2arb_req) begin
               grant_load = 1'b1;
               next_state = LOAD;
            end else if (bus.stb2arb_req) begin
               grant_store = 1'b1;
               next_state  = STORE;
            end
         end
         LOAD: begin
            if (bus.dcache2arb_ack) next_state = IDLE;
         end
         STORE: begin
            if (bus.dcache2arb_ack) next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= next_state;
   end

   // Counts loads that completed while a drain was waiting; any drain resets it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         starve_cnt <= 4'd0;
      end else if (grant_store) begin
         starve_cnt <= 4'd0;
      end else if (load_done && bus.stb2arb_req && (starve_cnt < LIMIT)) begin
         starve_cnt <= starve_cnt + 4'd1;
      end
   end

   // Request and payload are captured at grant and held untouched until the ack.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.arb2dcache_req      <= 1'b0;
         bus.arb2dcache_w_en     <= 1'b0;
         bus.arb2dcache_addr     <= '0;
         bus.arb2dcache_wdata    <= '0;
         bus.arb2dcache_sel_byte <= '0;
      end else if (grant_load) begin
         bus.arb2dcache_req      <= 1'b1;
         bus.arb2dcache_w_en     <= 1'b0;
         bus.arb2dcache_addr     <= bus.lsummu2arb_addr;
         bus.arb2dcache_wdata    <= '0;
         bus.arb2dcache_sel_byte <= bus.lsummu2arb_sel_byte;
      end else if (grant_store) begin
         bus.arb2dcache_req      <= 1'b1;
         bus.arb2dcache_w_en     <= 1'b1;
         bus.arb2dcache_addr     <= bus.stb2arb_addr;
         bus.arb2dcache_wdata    <= bus.stb2arb_wdata;
         bus.arb2dcache_sel_byte <= bus.stb2arb_sel_byte;
      end else if (load_done || store_done) begin
         bus.arb2dcache_req      <= 1'b0;
         bus.arb2dcache_w_en     <= 1'b0;
         bus.arb2dcache_addr     <= '0;
         bus.arb2dcache_wdata    <= '0;
         bus.arb2dcache_sel_byte <= '0;
      end
   end

endmodule
